// File: rtl/neighborhood_window.sv
// rtl/neighborhood_window.sv - raster-stream N x N neighbourhood window generator with line buffers
// Optional build macro: NEIGHBORHOOD_WINDOW_MASK_EN zeroes window entries that fall outside the frame.
module neighborhood_window #(
    parameter int N_SIZE = 5,
    parameter int COLORS = 1,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          sof,
    input  logic                                          pix_valid,
    input  logic [COLORS-1:0]                             pix_in,
    output logic [N_SIZE-1:0][N_SIZE-1:0][COLORS-1:0]     win_img,
    output logic                                          win_valid,
    output logic                                          win_interior,
    output logic [$clog2(IMG_W)-1:0]                      win_x,
    output logic [$clog2(IMG_H)-1:0]                      win_y
);

    localparam int XW   = $clog2(IMG_W);
    localparam int YW   = $clog2(IMG_H);
    localparam int NL   = N_SIZE - 1;
    localparam int HALF = N_SIZE / 2;

    localparam logic [XW-1:0] X_LAST  = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(IMG_H - 1);
    localparam logic [XW-1:0] X_HALF  = XW'(HALF);
    localparam logic [YW-1:0] Y_HALF  = YW'(HALF);
    localparam logic [XW-1:0] X_WRAP  = XW'(IMG_W - HALF);
    localparam logic [YW-1:0] Y_WRAP  = YW'(IMG_H - HALF);
    localparam logic [XW-1:0] X_EDGE  = XW'(NL);
    localparam logic [YW-1:0] Y_EDGE  = YW'(NL);

    typedef logic [COLORS-1:0] pix_t;

    // line_buf[k] holds the line k+1 rows above the current one
    pix_t line_buf [NL][IMG_W];

    logic [XW-1:0] col_cnt;
    logic [YW-1:0] row_cnt;
    logic [XW-1:0] cur_x;
    logic [YW-1:0] cur_y;
    logic [XW-1:0] cen_x;
    logic [YW-1:0] cen_y;
    logic          interior;
    pix_t          tap [N_SIZE];

    logic [N_SIZE-1:0][N_SIZE-1:0][COLORS-1:0] win_q;

    always_comb begin
        cur_x = col_cnt;
        cur_y = row_cnt;
        if (sof) begin
            cur_x = '0;
            cur_y = '0;
        end
        cen_x    = (cur_x >= X_HALF) ? cur_x - X_HALF : cur_x + X_WRAP;
        cen_y    = (cur_y >= Y_HALF) ? cur_y - Y_HALF : cur_y + Y_WRAP;
        interior = (cur_x >= X_EDGE) && (cur_y >= Y_EDGE);
    end

    always_comb begin
        tap[NL] = pix_in;
        for (int r = 0; r < NL; r++) begin
            tap[r] = line_buf[NL-1-r][cur_x];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (pix_valid) begin
            if (cur_x == X_LAST) begin
                col_cnt <= '0;
                row_cnt <= (cur_y == Y_LAST) ? '0 : cur_y + 1'b1;
            end else begin
                col_cnt <= cur_x + 1'b1;
                row_cnt <= cur_y;
            end
        end else if (sof) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end
    end

    // No reset: contents are only ever read through the window
    always_ff @(posedge clk) begin
        if (pix_valid) begin
            line_buf[0][cur_x] <= pix_in;
            for (int k = 1; k < NL; k++) begin
                line_buf[k][cur_x] <= line_buf[k-1][cur_x];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q        <= '0;
            win_valid    <= 1'b0;
            win_interior <= 1'b0;
            win_x        <= '0;
            win_y        <= '0;
        end else begin
            win_valid    <= pix_valid;
            win_interior <= pix_valid && interior;
            if (pix_valid) begin
                for (int r = 0; r < N_SIZE; r++) begin
                    for (int c = 0; c < NL; c++) begin
                        win_q[r][c] <= win_q[r][c+1];
                    end
                    win_q[r][NL] <= tap[r];
                end
                win_x <= cen_x;
                win_y <= cen_y;
            end
        end
    end

`ifdef NEIGHBORHOOD_WINDOW_MASK_EN
    logic [XW-1:0] last_x;
    logic [YW-1:0] last_y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_x <= '0;
            last_y <= '0;
        end else if (pix_valid) begin
            last_x <= cur_x;
            last_y <= cur_y;
        end
    end

    // Entry [r][c] is pixel (x-(NL-c), y-(NL-r)); blank it when that falls off the frame
    always_comb begin
        win_img = '0;
        for (int r = 0; r < N_SIZE; r++) begin
            for (int c = 0; c < N_SIZE; c++) begin
                if ((int'(last_y) + r >= NL) && (int'(last_x) + c >= NL)) begin
                    win_img[r][c] = win_q[r][c];
                end
            end
        end
    end
`else
    assign win_img = win_q;
`endif

endmodule

// File: tb/tb_neighborhood_window.sv
// tb/tb_neighborhood_window.sv - self-checking bench for neighborhood_window (8x6 frame, 5x5 window)
module tb_neighborhood_window;

    localparam int N = 5;
    localparam int W = 8;
    localparam int H = 6;
`ifdef NEIGHBORHOOD_WINDOW_MASK_EN
    localparam bit MASK = 1'b1;
`else
    localparam bit MASK = 1'b0;
`endif

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       sof;
    logic                       pix_valid;
    logic [0:0]                 pix_in;
    logic [N-1:0][N-1:0][0:0]   win_img;
    logic                       win_valid;
    logic                       win_interior;
    logic [2:0]                 win_x;
    logic [2:0]                 win_y;

    neighborhood_window #(.N_SIZE(N), .COLORS(1), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst_n(rst_n), .sof(sof), .pix_valid(pix_valid), .pix_in(pix_in),
        .win_img(win_img), .win_valid(win_valid), .win_interior(win_interior),
        .win_x(win_x), .win_y(win_y)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference: coordinate tracker, per-column pixel history, window of known values
    int mx, my, lx, ly;
    bit colhist[W][$];
    bit mval[N][N];
    bit mknown[N][N];
    bit e_valid, e_int;
    int e_x, e_y;

    bit capture;
    logic [N*N-1:0] capq[$];

    typedef struct {
        int x; int y; int ex; int ey; bit eint; bit p44; bit p00;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mx = 0; my = 0; lx = 0; ly = 0;
        e_valid = 0; e_int = 0; e_x = 0; e_y = 0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                mval[r][c] = 0;
                mknown[r][c] = 1;
            end
    endtask

    task automatic model_step(bit s, bit v, bit p);
        int x, y, sz;
        if (v) begin
            x = s ? 0 : mx;
            y = s ? 0 : my;
            colhist[x].push_back(p);
            sz = colhist[x].size();
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N-1; c++) begin
                    mval[r][c] = mval[r][c+1];
                    mknown[r][c] = mknown[r][c+1];
                end
                if (sz > N-1-r) begin
                    mval[r][N-1] = colhist[x][sz-1-(N-1-r)];
                    mknown[r][N-1] = 1;
                end else begin
                    mknown[r][N-1] = 0;
                end
            end
            e_valid = 1;
            e_int = (x >= N-1) && (y >= N-1);
            e_x = (x - N/2 + W) % W;
            e_y = (y - N/2 + H) % H;
            lx = x; ly = y;
            mx = (x + 1) % W;
            my = (x == W-1) ? (y + 1) % H : y;
        end else begin
            e_valid = 0;
            if (s) begin mx = 0; my = 0; end
        end
    endtask

    task automatic check_outputs();
        logic [N*N-1:0] act, exp, msk;
        act = win_img;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                if (MASK && !((ly + r >= N-1) && (lx + c >= N-1))) begin
                    exp[r*N+c] = 1'b0; msk[r*N+c] = 1'b1;
                end else begin
                    exp[r*N+c] = mval[r][c]; msk[r*N+c] = mknown[r][c];
                end
            end
        chk("win_valid", win_valid, e_valid);
        if (e_valid) begin
            chk("win_interior", win_interior, e_int);
            chk("win_x", win_x, e_x);
            chk("win_y", win_y, e_y);
        end
        chk("win_img", act & msk, exp & msk);
    endtask

    // Called at a negedge; applies one input cycle and checks the registered result
    task automatic cycle(bit s, bit v, bit p);
        sof = s; pix_valid = v; pix_in = p;
        @(posedge clk);
        model_step(s, v, p);
        @(negedge clk);
        check_outputs();
        if (capture && win_valid && win_interior) capq.push_back(win_img);
    endtask

    task automatic idle();
        sof = 0; pix_valid = 0; pix_in = 0;
    endtask

    initial begin
        bit img[W*H];
        logic [N*N-1:0] qa[$];
        logic [N*N-1:0] all_ones;
        int n_int, n_val;

        // Pattern pixel(x,y) = (y*8+x) mod 2 = x mod 2
        tbl[0] = '{x:6, y:5, ex:4, ey:3, eint:1, p44:0, p00:0};
        tbl[1] = '{x:7, y:4, ex:5, ey:2, eint:1, p44:1, p00:1};
        tbl[2] = '{x:0, y:0, ex:6, ey:4, eint:0, p44:0, p00:0};
        tbl[3] = '{x:3, y:2, ex:1, ey:0, eint:0, p44:1, p00:0};
        tbl[4] = '{x:4, y:4, ex:2, ey:2, eint:1, p44:0, p00:0};
        tbl[5] = '{x:5, y:4, ex:3, ey:2, eint:1, p44:1, p00:1};
        tbl[6] = '{x:1, y:5, ex:7, ey:3, eint:0, p44:1, p00:0};

        capture = 0;
        idle();
        rst_n = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs();
        chk("reset_interior", win_interior, 0);
        chk("reset_x", win_x, 0);
        chk("reset_y", win_y, 0);
        rst_n = 1;

        // 48 ones straight after reset, no sof
        n_int = 0; n_val = 0;
        for (int i = 0; i < W*H; i++) begin
            cycle(0, 1, 1);
            n_int += int'(win_interior);
            n_val += int'(win_valid);
        end
        chk("interior_count", n_int, 8);
        chk("valid_count", n_val, 48);

        // Second ones frame: window at (1,1) shows stale ones unless masked
        for (int i = 0; i < W*H; i++) begin
            cycle(i == 0, 1, 1);
            if (i == W + 1) begin
                all_ones = '0;
                for (int r = 0; r < N; r++)
                    for (int c = 0; c < N; c++)
                        all_ones[r*N+c] = (!MASK || (r >= 3 && c >= 3));
                chk("mask_at_1_1", win_img, all_ones);
                chk("mask_interior", win_interior, 0);
            end
        end

        // Pattern frame with table of hand-computed windows
        for (int i = 0; i < W*H; i++) begin
            cycle(i == 0, 1, (i % W) % 2);
            for (int k = 0; k < 7; k++) begin
                if (tbl[k].x == i % W && tbl[k].y == i / W) begin
                    chk("tbl_x", win_x, tbl[k].ex);
                    chk("tbl_y", win_y, tbl[k].ey);
                    chk("tbl_interior", win_interior, tbl[k].eint);
                    chk("tbl_p44", win_img[4][4], tbl[k].p44);
                    if (tbl[k].eint) chk("tbl_p00", win_img[0][0], tbl[k].p00);
                end
            end
        end

        // Same random frame gapless then with stalls: interior windows must match
        for (int i = 0; i < W*H; i++) img[i] = 1'($urandom);
        capq.delete();
        capture = 1;
        for (int i = 0; i < W*H; i++) cycle(i == 0, 1, img[i]);
        qa = capq;
        capq.delete();
        for (int i = 0; i < W*H; i++) begin
            repeat ($urandom_range(0, 2)) cycle(0, 0, 1'($urandom));
            cycle(i == 0, 1, img[i]);
        end
        capture = 0;
        chk("gap_count", capq.size(), qa.size());
        for (int i = 0; i < qa.size() && i < capq.size(); i++)
            chk("gap_window", capq[i], qa[i]);

        // sof at counter (3,2)
        for (int i = 0; i < 2*W + 3; i++) cycle(i == 0, 1, 1'($urandom));
        cycle(1, 1, 1'($urandom));
        chk("sof_x", win_x, 6);
        chk("sof_y", win_y, 4);
        cycle(0, 1, 1'($urandom));
        chk("sof_next_x", win_x, 7);
        chk("sof_next_y", win_y, 4);

        // Standalone sof then random traffic with occasional sof
        cycle(1, 0, 0);
        for (int i = 0; i < 300; i++)
            cycle(($urandom % 40) == 0, ($urandom % 4) != 0, 1'($urandom));

        // Reset mid-line after pixel (5,3)
        for (int i = 0; i < 3*W + 6; i++) cycle(i == 0, 1, 1'($urandom));
        idle();
        rst_n = 0;
        #1;
        model_reset();
        chk("async_valid", win_valid, 0);
        chk("async_interior", win_interior, 0);
        chk("async_x", win_x, 0);
        chk("async_y", win_y, 0);
        chk("async_img", win_img, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        cycle(0, 1, 1);
        chk("rst_next_x", win_x, 6);
        chk("rst_next_y", win_y, 4);
        for (int i = 0; i < 60; i++) cycle(0, ($urandom % 3) != 0, 1'($urandom));

        idle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
